mmio_hub: RTL and testbench

Parametrised memory-mapped I/O hub for the d16 CPU's top 256-byte address window. It replaces the fixed LED/UART decoder with N byte-wide LED/GPIO output ports, byte and word access, a UART register interface exposed as ports, and a 16-bit prescaled timer with compare match and interrupt. It sits between the CPU memory stage and the board peripherals; every read in the window completes with the registered `serviced_read` handshake.

---
 rtl/mmio_hub_if.sv | 22 ++
 rtl/mmio_hub.sv | 203 ++++++++++++++++++++
 tb/tb_mmio_hub.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_hub_if.sv
// CPU-side bus of the d16 MMIO hub: access strobe, address/data and the
// registered read-completion handshake.
interface mmio_hub_if;
    logic        en;
    logic        write_enable;
    logic        byte_select;
    logic        byte_enable;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        serviced_read;

    modport master (
        output en, write_enable, byte_select, byte_enable, addr, data_in,
        input  data_out, serviced_read
    );

    modport slave (
        input  en, write_enable, byte_select, byte_enable, addr, data_in,
        output data_out, serviced_read
    );
endinterface

// File: rtl/mmio_hub.sv
// Memory-mapped I/O hub for the top 256-byte window of the d16 CPU: LED/GPIO
// byte ports, UART register ports and a prescaled 16-bit timer with compare IRQ.
module mmio_hub #(
    parameter int          N_LED     = 1,
    parameter int          PRESCALE  = 1,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic               i_clk,
    input  logic               i_rst,
    mmio_hub_if.slave          bus,
    output logic [8*N_LED-1:0] o_led_out,
    output logic               o_uart_wr_en,
    output logic [7:0]         o_uart_wr_data,
    output logic               o_uart_rd_ack,
    input  logic [7:0]         i_uart_rx_data,
    input  logic [7:0]         i_uart_status,
    output logic               o_irq
);
    localparam logic [7:0]  OFF_UART_DATA = 8'h10;
    localparam logic [7:0]  OFF_UART_STAT = 8'h11;
    localparam logic [7:0]  OFF_CNT_LO    = 8'h20;
    localparam logic [7:0]  OFF_CNT_HI    = 8'h21;
    localparam logic [7:0]  OFF_CMP_LO    = 8'h22;
    localparam logic [7:0]  OFF_CMP_HI    = 8'h23;
    localparam logic [7:0]  OFF_CTRL      = 8'h24;
    localparam logic [7:0]  OFF_STAT      = 8'h25;
    localparam logic [15:0] PRESCALE_MAX  = 16'(PRESCALE - 1);

    logic [7:0]  r_led [N_LED];
    logic [15:0] r_count, r_compare, r_presc;
    logic [2:0]  r_ctrl;
    logic        r_flag;
    logic [7:0]  r_shadow;
    logic        r_p_rd, r_p_hit, r_p_ack, r_p_wr;
    logic [15:0] r_p_data;
    logic [7:0]  r_p_wdata;
    logic [15:0] r_data_out;
    logic        r_serviced, r_uart_wr_en, r_uart_rd_ack, r_irq;
    logic [7:0]  r_uart_wr_data;

    logic [15:0] w_ba, w_rd_data, w_count_nxt, w_presc_nxt;
    logic [7:0]  w_off0, w_off1, w_ctrl_wd, w_stat_wd;
    logic        w_hit, w_word, w_rd, w_wr, w_snap, w_rd_ack, w_uart_wr;
    logic        w_tick, w_match, w_cnt_wr, w_flag_nxt;
    logic        w_unused;

    // Byte address drops addr[15]; a word access is aligned so its second byte is off0|1.
    assign w_ba     = {bus.addr[14:0], bus.byte_select};
    assign w_unused = bus.addr[15];
    assign w_hit    = (w_ba[15:8] == BASE_ADDR[15:8]);
    assign w_word   = ~bus.byte_enable & ~bus.byte_select;
    assign w_off0   = w_ba[7:0];
    assign w_off1   = w_ba[7:0] | 8'h01;
    assign w_rd     = bus.en & ~bus.write_enable;
    assign w_wr     = bus.en & bus.write_enable & w_hit;
    assign w_snap   = w_rd & w_hit & ~w_word & (w_off0 == OFF_CNT_LO);
    assign w_rd_ack = w_rd & w_hit & (w_off0 == OFF_UART_DATA);

    function automatic logic wr_at(input logic [7:0] t);
        return (w_wr && (w_off0 == t)) || (w_wr && w_word && (w_off1 == t));
    endfunction

    function automatic logic [7:0] wr_data_at(input logic [7:0] t);
        return (w_word && (w_off1 == t)) ? bus.data_in[15:8] : bus.data_in[7:0];
    endfunction

    function automatic logic [7:0] rd_byte(input logic [7:0] off, input logic live_hi);
        logic [7:0] b;
        b = 8'h00;
        case (off)
            OFF_UART_DATA: b = i_uart_rx_data;
            OFF_UART_STAT: b = i_uart_status;
            OFF_CNT_LO:    b = r_count[7:0];
            OFF_CNT_HI:    b = live_hi ? r_count[15:8] : r_shadow;
            OFF_CMP_LO:    b = r_compare[7:0];
            OFF_CMP_HI:    b = r_compare[15:8];
            OFF_CTRL:      b = {5'b00000, r_ctrl};
            OFF_STAT:      b = {7'b0000000, r_flag};
            default: begin
                for (int i = 0; i < N_LED; i++) begin
                    if (off == 8'(i)) b = r_led[i];
                end
            end
        endcase
        return b;
    endfunction

    // Read data mux; a word read of the count returns the live high byte.
    always_comb begin
        w_rd_data = 16'h0000;
        if (w_word) begin
            w_rd_data = {rd_byte(w_off1, 1'b1), rd_byte(w_off0, 1'b1)};
        end else begin
            w_rd_data = {8'h00, rd_byte(w_off0, 1'b0)};
        end
    end

    // Timer next state: CPU count writes override the tick and restart the prescaler.
    always_comb begin
        w_uart_wr   = wr_at(OFF_UART_DATA);
        w_ctrl_wd   = wr_data_at(OFF_CTRL);
        w_stat_wd   = wr_data_at(OFF_STAT);
        w_tick      = r_ctrl[0] & (r_presc == PRESCALE_MAX);
        w_match     = w_tick & (r_count == r_compare);
        w_cnt_wr    = wr_at(OFF_CNT_LO) | wr_at(OFF_CNT_HI);
        w_count_nxt = r_count;
        w_presc_nxt = r_presc;
        if (r_ctrl[0]) begin
            w_presc_nxt = w_tick ? 16'h0000 : r_presc + 16'h0001;
        end else begin
            w_presc_nxt = r_presc;
        end
        if (w_cnt_wr) begin
            w_count_nxt = {wr_at(OFF_CNT_HI) ? wr_data_at(OFF_CNT_HI) : r_count[15:8],
                           wr_at(OFF_CNT_LO) ? wr_data_at(OFF_CNT_LO) : r_count[7:0]};
            w_presc_nxt = 16'h0000;
        end else if (w_match && r_ctrl[1]) begin
            w_count_nxt = 16'h0000;
        end else if (w_tick) begin
            w_count_nxt = r_count + 16'h0001;
        end else begin
            w_count_nxt = r_count;
        end
        if (wr_at(OFF_CTRL) && !w_ctrl_wd[0]) begin
            w_presc_nxt = 16'h0000;
        end else begin
            w_presc_nxt = w_presc_nxt;
        end
        if (w_match) begin
            w_flag_nxt = 1'b1;
        end else if (wr_at(OFF_STAT) && w_stat_wd[0]) begin
            w_flag_nxt = 1'b0;
        end else begin
            w_flag_nxt = r_flag;
        end
    end

    // Architectural register file and timer state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_LED; i++) r_led[i] <= 8'h00;
            r_count   <= 16'h0000;
            r_compare <= 16'hFFFF;
            r_presc   <= 16'h0000;
            r_ctrl    <= 3'b000;
            r_flag    <= 1'b0;
            r_shadow  <= 8'h00;
        end else begin
            for (int i = 0; i < N_LED; i++) begin
                if (wr_at(8'(i))) r_led[i] <= wr_data_at(8'(i));
            end
            if (wr_at(OFF_CMP_LO)) r_compare[7:0]  <= wr_data_at(OFF_CMP_LO);
            if (wr_at(OFF_CMP_HI)) r_compare[15:8] <= wr_data_at(OFF_CMP_HI);
            if (wr_at(OFF_CTRL))   r_ctrl          <= w_ctrl_wd[2:0];
            if (w_snap)            r_shadow        <= r_count[15:8];
            r_count <= w_count_nxt;
            r_presc <= w_presc_nxt;
            r_flag  <= w_flag_nxt;
        end
    end

    // One-stage response pipeline: requests sampled at edge N are presented after N+1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p_rd         <= 1'b0;
            r_p_hit        <= 1'b0;
            r_p_ack        <= 1'b0;
            r_p_wr         <= 1'b0;
            r_p_data       <= 16'h0000;
            r_p_wdata      <= 8'h00;
            r_data_out     <= 16'h0000;
            r_serviced     <= 1'b0;
            r_uart_rd_ack  <= 1'b0;
            r_uart_wr_en   <= 1'b0;
            r_uart_wr_data <= 8'h00;
            r_irq          <= 1'b0;
        end else begin
            r_p_rd        <= w_rd;
            r_p_hit       <= w_rd & w_hit;
            r_p_ack       <= w_rd_ack;
            r_p_wr        <= w_uart_wr;
            r_p_data      <= w_rd_data;
            r_p_wdata     <= bus.data_in[7:0];
            if (r_p_rd) r_data_out <= r_p_hit ? r_p_data : 16'h0000;
            if (r_p_wr) r_uart_wr_data <= r_p_wdata;
            r_serviced    <= r_p_hit;
            r_uart_rd_ack <= r_p_ack;
            r_uart_wr_en  <= r_p_wr;
            r_irq         <= r_flag & r_ctrl[2];
        end
    end

    for (genvar g = 0; g < N_LED; g++) begin : g_led
        assign o_led_out[8*g +: 8] = r_led[g];
    end

    assign bus.data_out      = r_data_out;
    assign bus.serviced_read = r_serviced;
    assign o_uart_wr_en      = r_uart_wr_en;
    assign o_uart_wr_data    = r_uart_wr_data;
    assign o_uart_rd_ack     = r_uart_rd_ack;
    assign o_irq             = r_irq;
endmodule

// File: tb/tb_mmio_hub.sv
// Randomised and directed bench for mmio_hub against a byte-map reference model.
module tb_mmio_hub;
    localparam int N_LED    = 4;
    localparam int PRESCALE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] led_out;
    logic        uart_wr_en, uart_rd_ack, irq;
    logic [7:0]  uart_wr_data, uart_rx_data, uart_status;
    int          n_cmp = 0;
    int          n_err = 0;

    mmio_hub_if bus_if ();

    mmio_hub #(.N_LED(N_LED), .PRESCALE(PRESCALE), .BASE_ADDR(16'hFF00)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus_if), .o_led_out(led_out),
        .o_uart_wr_en(uart_wr_en), .o_uart_wr_data(uart_wr_data),
        .o_uart_rd_ack(uart_rd_ack), .i_uart_rx_data(uart_rx_data),
        .i_uart_status(uart_status), .o_irq(irq)
    );

    always #5 clk = ~clk;

    // Reference state: byte map contents plus the expected response one edge behind.
    int m_led [N_LED];
    int m_count, m_cmp, m_ctrl, m_flag, m_presc, m_shadow;
    bit s_rd, s_hit, s_ack, s_wr;
    int s_data, s_wd;
    int e_data, e_srv, e_ack, e_wen, e_wdat, e_irq;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_led();
        return {8'(m_led[3]), 8'(m_led[2]), 8'(m_led[1]), 8'(m_led[0])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_LED; i++) m_led[i] = 0;
        m_count = 0; m_cmp = 'hFFFF; m_ctrl = 0; m_flag = 0; m_presc = 0; m_shadow = 0;
        s_rd = 0; s_hit = 0; s_ack = 0; s_wr = 0; s_data = 0; s_wd = 0;
        e_data = 0; e_srv = 0; e_ack = 0; e_wen = 0; e_wdat = 0; e_irq = 0;
    endtask

    function automatic int mread(input int off, input bit live);
        if (off < N_LED) return m_led[off];
        case (off)
            'h10: return int'(uart_rx_data);
            'h11: return int'(uart_status);
            'h20: return m_count & 'hFF;
            'h21: return live ? (m_count >> 8) : m_shadow;
            'h22: return m_cmp & 'hFF;
            'h23: return m_cmp >> 8;
            'h24: return m_ctrl;
            'h25: return m_flag;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        int ba, off, nc, cw, nctrl, nb;
        bit word, inwin, rd, tick, set, clr, cntw;
        if (s_rd) e_data = s_hit ? s_data : 0;
        e_srv = s_hit; e_ack = s_ack; e_wen = s_wr;
        if (s_wr) e_wdat = s_wd;
        e_irq = (m_flag != 0 && (m_ctrl & 4) != 0) ? 1 : 0;
        ba    = int'({bus_if.addr[14:0], bus_if.byte_select});
        off   = ba & 'hFF;
        inwin = (ba >> 8) == 'hFF;
        word  = !bus_if.byte_enable && !bus_if.byte_select;
        rd    = bus_if.en && !bus_if.write_enable;
        s_rd = rd; s_hit = rd && inwin; s_ack = s_hit && off == 'h10; s_wr = 0; s_data = 0;
        if (s_hit) begin
            s_data = word ? ((mread(off + 1, 1) << 8) | mread(off, 1)) : mread(off, 0);
            if (!word && off == 'h20) m_shadow = m_count >> 8;
        end
        set = 0; tick = 0; nc = m_count;
        if ((m_ctrl & 1) != 0) begin
            if (m_presc == PRESCALE - 1) begin tick = 1; m_presc = 0; end
            else m_presc++;
        end
        if (tick) begin
            if (m_count == m_cmp) begin
                set = 1;
                nc = ((m_ctrl & 2) != 0) ? 0 : (m_count + 1) & 'hFFFF;
            end else nc = (m_count + 1) & 'hFFFF;
        end
        cw = m_count; cntw = 0; clr = 0; nctrl = m_ctrl;
        nb = word ? 2 : 1;
        if (bus_if.en && bus_if.write_enable && inwin) begin
            for (int k = 0; k < nb; k++) begin
                int o, d;
                o = off + k;
                d = (k == 1) ? (int'(bus_if.data_in) >> 8) : (int'(bus_if.data_in) & 'hFF);
                if (o < N_LED) m_led[o] = d;
                else case (o)
                    'h10: begin s_wr = 1; s_wd = d; end
                    'h20: begin cw = (cw & 'hFF00) | d; cntw = 1; end
                    'h21: begin cw = (cw & 'hFF) | (d << 8); cntw = 1; end
                    'h22: m_cmp = (m_cmp & 'hFF00) | d;
                    'h23: m_cmp = (m_cmp & 'hFF) | (d << 8);
                    'h24: begin nctrl = d & 7; if ((d & 1) == 0) m_presc = 0; end
                    'h25: if ((d & 1) != 0) clr = 1;
                    default: ;
                endcase
            end
        end
        if (cntw) begin nc = cw; m_presc = 0; end
        m_count = nc; m_ctrl = nctrl;
        m_flag = set ? 1 : (clr ? 0 : m_flag);
    endtask

    task automatic check_all();
        chk_eq("data_out", bus_if.data_out, e_data);
        chk_eq("serviced_read", bus_if.serviced_read, e_srv);
        chk_eq("led_out", led_out, exp_led());
        chk_eq("uart_wr_en", uart_wr_en, e_wen);
        chk_eq("uart_wr_data", uart_wr_data, e_wdat);
        chk_eq("uart_rd_ack", uart_rd_ack, e_ack);
        chk_eq("irq", irq, e_irq);
    endtask

    // One bus cycle at byte address ba; be=0 with an even ba is a word access.
    task automatic acc(input bit en, input bit we, input bit be, input int ba, input int din);
        @(negedge clk);
        bus_if.en           = en;
        bus_if.write_enable = we;
        bus_if.byte_enable  = be;
        bus_if.addr         = 16'(ba >> 1);
        bus_if.byte_select  = ba[0];
        bus_if.data_in      = 16'(din);
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    task automatic idle();
        acc(1'b0, 1'b0, 1'b1, 0, 0);
    endtask

    initial begin
        int offs [18] = '{0, 1, 2, 3, 4, 5, 6, 7, 'h10, 'h11, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h30, 'hFF};
        bit saw_irq;
        rst = 1'b1;
        bus_if.en = 1'b0; bus_if.write_enable = 1'b0; bus_if.byte_enable = 1'b1;
        bus_if.byte_select = 1'b0; bus_if.addr = 16'h0000; bus_if.data_in = 16'h0000;
        uart_rx_data = 8'h00; uart_status = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1 check_all();

        // LED byte and word access
        acc(1, 1, 1, 'hFF02, 'h5A);
        chk_eq("led_byte_wr", led_out, 32'h005A0000);
        acc(1, 0, 1, 'hFF02, 0);
        idle();
        chk_eq("led_byte_rd", bus_if.data_out, 16'h005A);
        chk_eq("led_byte_srv", bus_if.serviced_read, 1'b1);
        acc(1, 1, 0, 'hFF00, 'hBEEF);
        chk_eq("led_word_wr", led_out, 32'h005ABEEF);
        acc(1, 0, 0, 'hFF00, 0);
        idle();
        chk_eq("led_word_rd", bus_if.data_out, 16'hBEEF);
        acc(1, 0, 1, 'hFF08, 0);
        idle();
        chk_eq("unmapped_rd", bus_if.data_out, 16'h0000);

        // UART ports
        acc(1, 1, 1, 'hFF10, 'h41);
        idle();
        chk_eq("uart_tx_pulse", uart_wr_en, 1'b1);
        chk_eq("uart_tx_data", uart_wr_data, 8'h41);
        uart_rx_data = 8'h7E;
        acc(1, 0, 1, 'hFF10, 0);
        idle();
        chk_eq("uart_rx_rd", bus_if.data_out, 16'h007E);
        chk_eq("uart_rx_ack", uart_rd_ack, 1'b1);
        acc(1, 0, 1, 'h0100, 0);
        idle();
        chk_eq("outside_srv", bus_if.serviced_read, 1'b0);

        // Timer: compare 3, run + clear-on-match + irq enable
        acc(1, 1, 0, 'hFF22, 'h0003);
        acc(1, 1, 0, 'hFF20, 'h0000);
        acc(1, 1, 1, 'hFF24, 'h07);
        saw_irq = 0;
        for (int i = 0; i < 24; i++) begin
            acc(1, 0, 0, 'hFF20, 0);
            if (irq) saw_irq = 1;
        end
        chk_eq("irq_on_match", saw_irq, 1'b1);
        acc(1, 1, 1, 'hFF25, 'h01);
        idle();
        idle();
        chk_eq("irq_cleared", irq, 1'b0);
        saw_irq = 0;
        for (int i = 0; i < 12; i++) begin
            acc(1, 1, 1, 'hFF25, 'h01);
            if (irq) saw_irq = 1;
        end
        chk_eq("set_beats_clear", saw_irq, 1'b1);

        // Coherent count read across a tick
        acc(1, 1, 1, 'hFF24, 'h00);
        acc(1, 1, 0, 'hFF20, 'h12FF);
        acc(1, 1, 0, 'hFF22, 'hFFFF);
        acc(1, 1, 1, 'hFF24, 'h01);
        idle(); idle(); idle();
        acc(1, 0, 1, 'hFF20, 0);
        acc(1, 0, 1, 'hFF21, 0);
        chk_eq("shadow_lo", bus_if.data_out, 16'h00FF);
        idle();
        chk_eq("shadow_hi", bus_if.data_out, 16'h0012);

        // Random traffic, mostly inside the window
        for (int i = 0; i < 400; i++) begin
            int sel, ba;
            uart_rx_data = 8'($urandom);
            uart_status  = 8'($urandom);
            sel = int'($urandom_range(0, 19));
            ba  = (sel < 18) ? ('hFF00 | offs[sel]) : int'($urandom_range(0, 'hFFFF));
            acc(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), ba, int'($urandom_range(0, 'hFFFF)));
        end

        // Reset during a pending read
        acc(1, 1, 1, 'hFF01, 'hA5);
        acc(1, 0, 0, 'hFF22, 0);
        #2 rst = 1'b1;
        #1;
        chk_eq("rst_srv", bus_if.serviced_read, 1'b0);
        chk_eq("rst_data", bus_if.data_out, 16'h0000);
        chk_eq("rst_led", led_out, 32'h00000000);
        chk_eq("rst_irq", irq, 1'b0);
        chk_eq("rst_pulses", {uart_wr_en, uart_rd_ack}, 2'b00);
        @(negedge clk); bus_if.en = 1'b0;
        @(posedge clk); #1;
        chk_eq("abort_srv", bus_if.serviced_read, 1'b0);
        @(negedge clk); rst = 1'b0;
        model_reset();
        idle();
        chk_eq("post_rst_srv", bus_if.serviced_read, 1'b0);
        acc(1, 0, 0, 'hFF22, 0);
        idle();
        chk_eq("rst_compare", bus_if.data_out, 16'hFFFF);
        acc(1, 0, 0, 'hFF20, 0);
        acc(1, 0, 0, 'hFF24, 0);
        chk_eq("rst_count", bus_if.data_out, 16'h0000);
        idle();
        chk_eq("rst_ctrl_flag", bus_if.data_out, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
